// File: rtl/display_scheduler_if.sv
// display_scheduler_if: scan, game-logic RAM arbitration and tile-drawer handshake bundle.
interface display_scheduler_if;
   logic       frame_tick;
   logic       game_req;
   logic [7:0] game_addr;
   logic       game_gnt;
   logic [7:0] ram_addr;
   logic [7:0] ram_rdata;
   logic [7:0] cell_addr;
   logic [7:0] cell_data;
   logic       draw_start;
   logic       draw_done;
   logic       busy;
   logic       frame_done;
   logic       overrun;
   logic       draw_err;
   modport master (
      input  frame_tick, game_req, game_addr, ram_rdata, draw_done,
      output game_gnt, ram_addr, cell_addr, cell_data, draw_start, busy, frame_done, overrun, draw_err
   );
   modport slave (
      output frame_tick, game_req, game_addr, ram_rdata, draw_done,
      input  game_gnt, ram_addr, cell_addr, cell_data, draw_start, busy, frame_done, overrun, draw_err
   );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: walks the 10x10 board once per frame, feeding non-empty cells to the tile drawer.
// Optional draw watchdog enabled by defining DISP_SCHED_WATCHDOG_EN.
module display_scheduler #(
   parameter int COLS        = 10,
   parameter int ROWS        = 10,
   parameter int RAM_LAT     = 1,
   parameter int TIMEOUT_CYC = 1023
) (
   input logic clock,
   input logic resetn,
   display_scheduler_if.master bus
);
   typedef enum logic [2:0] {IDLE, GRANT, ADDR, WAIT, CLASS, DRAW, NEXT} state_t;
   state_t     state;
   logic [3:0] row, col;
   logic [1:0] lat;
   logic       pending;
   logic       last_col, last_cell;
   assign last_col      = col == 4'(COLS - 1);
   assign last_cell     = last_col && row == 4'(ROWS - 1);
   assign bus.game_gnt  = state == GRANT;
   assign bus.ram_addr  = bus.game_gnt ? bus.game_addr : {row, col};
`ifdef DISP_SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT_CYC + 1);
   logic [WDW-1:0] wd;
   logic           err;
   assign bus.draw_err = err;
`else
   assign bus.draw_err = 1'b0;
`endif
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         row            <= '0;
         col            <= '0;
         lat            <= '0;
         pending        <= 1'b0;
         bus.busy       <= 1'b0;
         bus.cell_addr  <= '0;
         bus.cell_data  <= '0;
         bus.draw_start <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overrun    <= 1'b0;
`ifdef DISP_SCHED_WATCHDOG_EN
         wd             <= '0;
         err            <= 1'b0;
`endif
      end else begin
         bus.draw_start <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.frame_tick && bus.busy) bus.overrun <= 1'b1;
         // a tick that lands while game logic holds the port outside a scan is kept for later
         if (bus.frame_tick && !bus.busy && state != IDLE) pending <= 1'b1;
         case (state)
            IDLE:
               if (bus.game_req) begin
                  state   <= GRANT;
                  pending <= pending | bus.frame_tick;
               end else if (bus.frame_tick || pending) begin
                  state    <= ADDR;
                  bus.busy <= 1'b1;
                  pending  <= 1'b0;
                  row      <= '0;
                  col      <= '0;
               end
            GRANT: if (!bus.game_req) state <= bus.busy ? ADDR : IDLE;
            ADDR: begin
               lat   <= 2'(RAM_LAT - 1);
               state <= WAIT;
            end
            WAIT:
               if (lat == '0) begin
                  bus.cell_data <= bus.ram_rdata;
                  bus.cell_addr <= {row, col};
                  state         <= CLASS;
               end else lat <= lat - 2'd1;
            CLASS:
               if (bus.cell_data == '0) state <= NEXT;
               else begin
                  bus.draw_start <= 1'b1;
                  state          <= DRAW;
`ifdef DISP_SCHED_WATCHDOG_EN
                  wd             <= '0;
`endif
               end
`ifdef DISP_SCHED_WATCHDOG_EN
            DRAW:
               if (bus.draw_done) state <= NEXT;
               else if (wd == WDW'(TIMEOUT_CYC - 1)) begin
                  err   <= 1'b1;
                  state <= NEXT;
               end else wd <= wd + 1'b1;
`else
            DRAW: if (bus.draw_done) state <= NEXT;
`endif
            NEXT:
               if (last_cell) begin
                  bus.frame_done <= 1'b1;
                  bus.busy       <= 1'b0;
                  row            <= '0;
                  col            <= '0;
                  state          <= IDLE;
               end else begin
                  col   <= last_col ? 4'd0 : col + 4'd1;
                  row   <= last_col ? row + 4'd1 : row;
                  state <= bus.game_req ? GRANT : ADDR;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of scan order, drawer handshake, RAM arbitration, overrun and reset.
module tb_display_scheduler;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;
   display_scheduler_if bus ();
`ifdef DISP_SCHED_WATCHDOG_EN
   display_scheduler #(.TIMEOUT_CYC(16)) dut (.clock(clock), .resetn(resetn), .bus(bus));
   localparam int D3 = 8;
   localparam logic WD = 1'b1;
`else
   display_scheduler dut (.clock(clock), .resetn(resetn), .bus(bus));
   localparam int D3 = 64;
   localparam logic WD = 1'b0;
`endif
   logic [7:0] mem [256];
   always @(posedge clock) bus.ram_rdata <= mem[bus.ram_addr];
   int checks = 0, failures = 0;
   int n_start, n_fd, n_busy, n_gnt_bad, stab_err, dcnt, done_delay, k, s, errs;
   logic [7:0] log_addr [128];
   logic [7:0] log_data [128];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic chk_outputs_zero(input string tag);
      chk(tag, {bus.game_gnt, bus.ram_addr, bus.cell_addr, bus.cell_data, bus.draw_start,
                bus.busy, bus.frame_done, bus.overrun, bus.draw_err}, 32'd0);
   endtask
   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask
   task automatic clr();
      n_start = 0; n_fd = 0; n_busy = 0; n_gnt_bad = 0; stab_err = 0;
   endtask
   task automatic tick();
      @(posedge clock); #1 bus.frame_tick = 1'b1;
      @(posedge clock); #1 bus.frame_tick = 1'b0;
   endtask
   task automatic wait_fd(output int cyc);
      cyc = 0;
      while (!bus.frame_done && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
      chk("frame_done_seen", bus.frame_done, 1'b1);
   endtask
   task automatic chk_seq(input string tag);
      errs = 0;
      for (int i = 0; i < 100; i++) if (log_addr[i] !== 8'((i / 10) * 16 + i % 10)) errs++;
      chk(tag, errs, 0);
   endtask
   // tile-drawer model and event log, sampled on the falling edge
   initial begin
      bus.draw_done = 1'b0;
      dcnt = 0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            dcnt = 0;
            bus.draw_done = 1'b0;
         end else begin
            if (dcnt > 0) begin
               if (n_start > 0 && n_start <= 128 && (bus.cell_addr !== log_addr[n_start-1] ||
                   bus.cell_data !== log_data[n_start-1])) stab_err++;
               if (bus.game_gnt) n_gnt_bad++;
               dcnt--;
               bus.draw_done = dcnt == 0;
            end else bus.draw_done = 1'b0;
            if (bus.draw_start) begin
               if (n_start < 128) begin
                  log_addr[n_start] = bus.cell_addr;
                  log_data[n_start] = bus.cell_data;
               end
               n_start++;
               dcnt = done_delay;
            end
            if (bus.frame_done) n_fd++;
            if (bus.busy) n_busy++;
         end
      end
   end
   initial begin
      bus.frame_tick = 1'b0;
      bus.game_req = 1'b0;
      bus.game_addr = 8'h00;
      done_delay = 1;
      clr();
      fill(8'h00);
      #12 chk_outputs_zero("reset_outputs");
      @(posedge clock); #1 resetn = 1'b1;
      repeat (3) @(negedge clock);
      chk_outputs_zero("idle_outputs");
      // empty board
      clr();
      tick();
      wait_fd(k);
      chk("empty_frame_cycles", k, 401);
      repeat (5) @(negedge clock);
      chk("empty_draw_starts", n_start, 0);
      chk("empty_frame_done_once", n_fd, 1);
      chk("empty_busy_cycles", n_busy, 400);
      chk("empty_busy_end", bus.busy, 1'b0);
      // single tank cell at 0x23
      clr();
      mem[8'h23] = 8'h40;
      done_delay = D3;
      tick();
      wait_fd(k);
      chk("single_frame_cycles", k, 402 + D3);
      repeat (3) @(negedge clock);
      chk("single_draw_starts", n_start, 1);
      chk("single_cell_addr", log_addr[0], 8'h23);
      chk("single_cell_data", log_data[0], 8'h40);
      chk("single_stable", stab_err, 0);
      chk("single_err", bus.draw_err, 1'b0);
      // game request during the draw of cell 0x05
      clr();
      fill(8'h10);
      done_delay = 3;
      tick();
      k = 0;
      while (!(bus.draw_start && bus.cell_addr == 8'h05) && k < 500) begin
         @(negedge clock);
         k++;
      end
      chk("cell05_reached", bus.cell_addr, 8'h05);
      bus.game_addr = 8'h77;
      bus.game_req = 1'b1;
      k = 0;
      while (!bus.game_gnt && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("gnt_latency", k, 5);
      chk("gnt_ram_addr", bus.ram_addr, 8'h77);
      s = 0;
      repeat (4) begin
         @(negedge clock);
         if (bus.game_gnt) s++;
      end
      chk("gnt_hold", s, 4);
      bus.game_req = 1'b0;
      chk("gnt_drop_same_cycle", bus.game_gnt, 1'b1);
      @(negedge clock);
      chk("gnt_drop_next_cycle", bus.game_gnt, 1'b0);
      wait_fd(k);
      repeat (3) @(negedge clock);
      chk("arb_draw_starts", n_start, 100);
      chk_seq("arb_sequence");
      chk("arb_stable", stab_err, 0);
      chk("arb_no_gnt_in_draw", n_gnt_bad, 0);
      // frame_tick and game_req together in IDLE
      clr();
      done_delay = 1;
      @(posedge clock); #1;
      bus.frame_tick = 1'b1;
      bus.game_req = 1'b1;
      bus.game_addr = 8'h42;
      @(posedge clock); #1 bus.frame_tick = 1'b0;
      @(negedge clock);
      chk("both_gnt", bus.game_gnt, 1'b1);
      chk("both_busy", bus.busy, 1'b0);
      chk("both_ram_addr", bus.ram_addr, 8'h42);
      @(posedge clock); #1 bus.game_req = 1'b0;
      wait_fd(k);
      repeat (3) @(negedge clock);
      chk("both_draw_starts", n_start, 100);
      chk_seq("both_sequence");
      // second tick mid-scan
      clr();
      tick();
      repeat (50) @(negedge clock);
      chk("overrun_before", bus.overrun, 1'b0);
      tick();
      @(negedge clock);
      chk("overrun_set", bus.overrun, 1'b1);
      wait_fd(k);
      repeat (20) @(negedge clock);
      chk("overrun_draw_starts", n_start, 100);
      chk_seq("overrun_sequence");
      chk("overrun_frame_done_once", n_fd, 1);
      chk("overrun_no_restart", bus.busy, 1'b0);
      chk("overrun_sticky", bus.overrun, 1'b1);
      // drawer never answers on wall cell 0x00, then reset mid-draw
      clr();
      fill(8'h00);
      mem[8'h00] = 8'h80;
      done_delay = 0;
      tick();
      k = 0;
      while (!bus.draw_start && k < 50) begin
         @(negedge clock);
         k++;
      end
      chk("stuck_cell_addr", bus.cell_addr, 8'h00);
      chk("stuck_cell_data", bus.cell_data, 8'h80);
      repeat (20) @(negedge clock);
      chk("watchdog_flag", bus.draw_err, WD);
      chk("stuck_busy", bus.busy, 1'b1);
      @(posedge clock); #2 resetn = 1'b0;
      #1 chk_outputs_zero("async_reset_outputs");
      @(posedge clock); #1 resetn = 1'b1;
      s = n_start;
      repeat (30) @(negedge clock);
      chk("no_draw_after_reset", n_start, s);
      chk("idle_after_reset", bus.busy, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
